// File: rtl/shapool_spi_frontend_if.sv
// Pin-side and core-side signal bundle of the shapool SPI front end.
// master = board/core side driving the pins and result; slave = front end.
interface shapool_spi_frontend_if #(
    parameter int GLOBAL_WIDTH = 608,
    parameter int DAISY_WIDTH  = 32
);
    logic                    sck0_in;
    logic                    sdi0_in;
    logic                    cs0_n_in;
    logic                    sck1_in;
    logic                    sdi1_in;
    logic                    cs1_n_in;
    logic                    sdo1_out;
    logic                    core_busy;
    logic                    core_result_valid;
    logic [DAISY_WIDTH-1:0]  core_result;
    logic [GLOBAL_WIDTH-1:0] global_data;
    logic                    global_valid;
    logic [DAISY_WIDTH-1:0]  daisy_data;
    logic                    daisy_valid;
    logic                    frame_err;
    logic                    status_led_n_out;

    modport master (
        output sck0_in, sdi0_in, cs0_n_in, sck1_in, sdi1_in, cs1_n_in,
        output core_busy, core_result_valid, core_result,
        input  sdo1_out, global_data, global_valid, daisy_data, daisy_valid,
        input  frame_err, status_led_n_out
    );

    modport slave (
        input  sck0_in, sdi0_in, cs0_n_in, sck1_in, sdi1_in, cs1_n_in,
        input  core_busy, core_result_valid, core_result,
        output sdo1_out, global_data, global_valid, daisy_data, daisy_valid,
        output frame_err, status_led_n_out
    );
endinterface

// File: rtl/shapool_spi_frontend.sv
// Oversampled global/daisy SPI deframer with daisy result shift-out,
// open-drain READY and status LED for the shapool hashing core.
//
// Result FSM:
//   state        | meaning
//   ST_IDLE      | no result waiting to be reported
//   ST_PENDING   | result held, READY asserted, waiting for a daisy frame
//   ST_IN_FLIGHT | result loaded into the daisy shifter, frame in progress
module shapool_spi_frontend #(
    parameter int GLOBAL_WIDTH = 608,
    parameter int DAISY_WIDTH  = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int LED_DIV_LOG2 = 22
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    shapool_spi_frontend_if.slave bus,
    output wire                   ready_n_od_out
);

    localparam int P_SCK0 = 0;
    localparam int P_SDI0 = 1;
    localparam int P_CS0  = 2;
    localparam int P_SCK1 = 3;
    localparam int P_SDI1 = 4;
    localparam int P_CS1  = 5;
    // cs_n pins idle high so a reset never fabricates a frame edge
    localparam logic [5:0] PIN_RST = 6'b100100;

    localparam int CNT0_W = $clog2(GLOBAL_WIDTH + 2);
    localparam int CNT1_W = $clog2(DAISY_WIDTH + 2);
    localparam logic [CNT0_W-1:0] GW_CNT = CNT0_W'(GLOBAL_WIDTH);
    localparam logic [CNT0_W-1:0] GW_SAT = CNT0_W'(GLOBAL_WIDTH + 1);
    localparam logic [CNT1_W-1:0] DW_CNT = CNT1_W'(DAISY_WIDTH);
    localparam logic [CNT1_W-1:0] DW_SAT = CNT1_W'(DAISY_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PENDING   = 2'd1,
        ST_IN_FLIGHT = 2'd2
    } state_t;

    logic [5:0] r_sync [SYNC_STAGES];
    logic       r_prev_sck0;
    logic       r_prev_cs0;
    logic       r_prev_sck1;
    logic       r_prev_cs1;

    logic [5:0] w_pins;
    logic [5:0] w_s;
    logic       w_sck0_rise;
    logic       w_cs0_fall;
    logic       w_cs0_rise;
    logic       w_sck1_rise;
    logic       w_sck1_fall;
    logic       w_cs1_fall;
    logic       w_cs1_rise;

    logic [GLOBAL_WIDTH-1:0] r_sr0;
    logic [CNT0_W-1:0]       r_cnt0;
    logic [GLOBAL_WIDTH-1:0] r_global_data;
    logic                    r_global_valid;

    logic                    r_sample1;
    logic [DAISY_WIDTH-1:0]  r_sr1;
    logic [CNT1_W-1:0]       r_cnt1;
    logic [DAISY_WIDTH-1:0]  r_daisy_data;
    logic                    r_daisy_valid;
    logic [DAISY_WIDTH-1:0]  r_result;
    logic                    r_frame_err;

    state_t r_state;
    state_t w_next;
    logic   w_pending;
    logic   w_load_result;
    logic   w_global_ok;
    logic   w_daisy_ok;

    logic [LED_DIV_LOG2-1:0] r_led_cnt;
    logic                    r_blink_n;

    assign w_pins = {bus.cs1_n_in, bus.sdi1_in, bus.sck1_in,
                     bus.cs0_n_in, bus.sdi0_in, bus.sck0_in};

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= PIN_RST;
            r_prev_sck0 <= 1'b0;
            r_prev_cs0  <= 1'b1;
            r_prev_sck1 <= 1'b0;
            r_prev_cs1  <= 1'b1;
        end else begin
            r_sync[0] <= w_pins;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev_sck0 <= w_s[P_SCK0];
            r_prev_cs0  <= w_s[P_CS0];
            r_prev_sck1 <= w_s[P_SCK1];
            r_prev_cs1  <= w_s[P_CS1];
        end
    end

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_sck0_rise =  w_s[P_SCK0] & ~r_prev_sck0;
    assign w_cs0_fall  = ~w_s[P_CS0]  &  r_prev_cs0;
    assign w_cs0_rise  =  w_s[P_CS0]  & ~r_prev_cs0;
    assign w_sck1_rise =  w_s[P_SCK1] & ~r_prev_sck1;
    assign w_sck1_fall = ~w_s[P_SCK1] &  r_prev_sck1;
    assign w_cs1_fall  = ~w_s[P_CS1]  &  r_prev_cs1;
    assign w_cs1_rise  =  w_s[P_CS1]  & ~r_prev_cs1;

    assign w_global_ok = (r_cnt0 == GW_CNT);
    assign w_daisy_ok  = (r_cnt1 == DW_CNT);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_sr0          <= '0;
            r_cnt0         <= '0;
            r_global_data  <= '0;
            r_global_valid <= 1'b0;
        end else begin
            r_global_valid <= 1'b0;
            if (w_cs0_fall) begin
                r_cnt0 <= '0;
            end else if (w_sck0_rise && !w_s[P_CS0]) begin
                r_sr0 <= {r_sr0[GLOBAL_WIDTH-2:0], w_s[P_SDI0]};
                if (r_cnt0 != GW_SAT) r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_cs0_rise && w_global_ok) begin
                r_global_data  <= r_sr0;
                r_global_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_sample1     <= 1'b0;
            r_sr1         <= '0;
            r_cnt1        <= '0;
            r_daisy_data  <= '0;
            r_daisy_valid <= 1'b0;
        end else begin
            r_daisy_valid <= 1'b0;
            if (w_sck1_rise) r_sample1 <= w_s[P_SDI1];
            if (w_cs1_fall) begin
                r_sr1 <= w_load_result ? r_result : '0;
            end else if (w_sck1_fall) begin
                r_sr1 <= {r_sr1[DAISY_WIDTH-2:0], r_sample1};
            end
            if (w_cs1_fall) begin
                r_cnt1 <= '0;
            end else if (w_sck1_rise && !w_s[P_CS1] && r_cnt1 != DW_SAT) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
            if (w_cs1_rise && w_daisy_ok) begin
                r_daisy_data  <= r_sr1;
                r_daisy_valid <= 1'b1;
            end
        end
    end

    // Bad global and bad daisy closing together still give a single pulse
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_frame_err <= 1'b0;
            r_result    <= '0;
        end else begin
            r_frame_err <= (w_cs0_rise && !w_global_ok) ||
                           (w_cs1_rise && !w_daisy_ok);
            if (bus.core_result_valid) r_result <= bus.core_result;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) r_state <= ST_IDLE;
        else             r_state <= w_next;
    end

    // A fresh result always wins, so it survives the frame that is closing
    always_comb begin
        w_next = r_state;
        if (bus.core_result_valid) begin
            w_next = ST_PENDING;
        end else begin
            case (r_state)
                ST_PENDING:   if (w_cs1_fall) w_next = ST_IN_FLIGHT;
                ST_IN_FLIGHT: if (w_cs1_rise) w_next = w_daisy_ok ? ST_IDLE : ST_PENDING;
                default:      w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_pending     = (r_state != ST_IDLE);
        w_load_result = w_pending && w_cs1_fall;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_led_cnt <= '0;
            r_blink_n <= 1'b1;
        end else if (!bus.core_busy) begin
            r_led_cnt <= '0;
            r_blink_n <= 1'b1;
        end else begin
            r_led_cnt <= r_led_cnt + 1'b1;
            if (&r_led_cnt) r_blink_n <= ~r_blink_n;
        end
    end

    assign bus.sdo1_out         = r_sr1[DAISY_WIDTH-1];
    assign bus.global_data      = r_global_data;
    assign bus.global_valid     = r_global_valid;
    assign bus.daisy_data       = r_daisy_data;
    assign bus.daisy_valid      = r_daisy_valid;
    assign bus.frame_err        = r_frame_err;
    assign bus.status_led_n_out = w_pending ? 1'b0 : (bus.core_busy ? r_blink_n : 1'b1);
    assign ready_n_od_out       = w_pending ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_shapool_spi_frontend.sv
// Directed bench for shapool_spi_frontend: global frame table plus
// hand-written daisy, LED and reset sequences.
module tb_shapool_spi_frontend;

    localparam int GW = 16;
    localparam int DW = 32;
    localparam int SS = 2;
    localparam int LD = 3;
    localparam int H  = SS + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire  w_ready_n;
    pullup (w_ready_n);

    shapool_spi_frontend_if #(.GLOBAL_WIDTH(GW), .DAISY_WIDTH(DW)) bus ();

    shapool_spi_frontend #(
        .GLOBAL_WIDTH(GW), .DAISY_WIDTH(DW), .SYNC_STAGES(SS), .LED_DIV_LOG2(LD)
    ) dut (
        .clk_in         (clk),
        .reset_n_in     (rst_n),
        .bus            (bus.slave),
        .ready_n_od_out (w_ready_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mon_gv = 0;
    int mon_dv = 0;
    int mon_fe = 0;

    always @(negedge clk) begin
        if (bus.global_valid) mon_gv <= mon_gv + 1;
        if (bus.daisy_valid)  mon_dv <= mon_dv + 1;
        if (bus.frame_err)    mon_fe <= mon_fe + 1;
    end

    typedef struct {
        int          nbits;
        logic [31:0] data;
        int          exp_valid;
        int          exp_err;
        logic [15:0] exp_gdata;
    } gvec_t;

    gvec_t gv [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gbit(input logic b);
        bus.sdi0_in = b;
        cyc(H);
        bus.sck0_in = 1'b1;
        cyc(H);
        bus.sck0_in = 1'b0;
    endtask

    task automatic gframe(input int n, input logic [31:0] data);
        bus.cs0_n_in = 1'b0;
        cyc(H);
        for (int i = n - 1; i >= 0; i--) gbit(data[i]);
        cyc(H);
        bus.cs0_n_in = 1'b1;
        cyc(2 * H);
    endtask

    task automatic dframe(input int n, input logic [63:0] din, output logic [63:0] seen);
        seen = '0;
        bus.cs1_n_in = 1'b0;
        cyc(H);
        for (int i = 0; i < n; i++) begin
            bus.sdi1_in = din[n-1-i];
            cyc(H);
            seen[n-1-i] = bus.sdo1_out;
            bus.sck1_in = 1'b1;
            cyc(H);
            bus.sck1_in = 1'b0;
        end
        cyc(H);
        bus.cs1_n_in = 1'b1;
        cyc(2 * H);
    endtask

    task automatic strobe(input logic [31:0] v);
        bus.core_result       = v;
        bus.core_result_valid = 1'b1;
        cyc(1);
        bus.core_result_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] seen;
        int gv0, dv0, fe0, k;
        logic prev;

        gv[0] = '{16, 32'h0000A55A, 1, 0, 16'hA55A};
        gv[1] = '{15, 32'h00001234, 0, 1, 16'hA55A};
        gv[2] = '{17, 32'h0001FFFF, 0, 1, 16'hA55A};
        gv[3] = '{16, 32'h00000001, 1, 0, 16'h0001};
        gv[4] = '{0,  32'h00000000, 0, 1, 16'h0001};
        gv[5] = '{16, 32'h0000FFFF, 1, 0, 16'hFFFF};

        bus.sck0_in = 0; bus.sdi0_in = 0; bus.cs0_n_in = 1;
        bus.sck1_in = 0; bus.sdi1_in = 0; bus.cs1_n_in = 1;
        bus.core_busy = 0; bus.core_result_valid = 0; bus.core_result = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(4);

        check("rst_sdo1",   64'(bus.sdo1_out), 64'd0);
        check("rst_gdata",  64'(bus.global_data), 64'd0);
        check("rst_gvalid", 64'(bus.global_valid), 64'd0);
        check("rst_ddata",  64'(bus.daisy_data), 64'd0);
        check("rst_dvalid", 64'(bus.daisy_valid), 64'd0);
        check("rst_ferr",   64'(bus.frame_err), 64'd0);
        check("rst_ready",  64'(w_ready_n), 64'd1);
        check("rst_led",    64'(bus.status_led_n_out), 64'd1);

        for (int v = 0; v < 6; v++) begin
            gv0 = mon_gv; fe0 = mon_fe;
            gframe(gv[v].nbits, gv[v].data);
            check($sformatf("gvec%0d_valid", v), 64'(mon_gv - gv0), 64'(gv[v].exp_valid));
            check($sformatf("gvec%0d_err", v),   64'(mon_fe - fe0), 64'(gv[v].exp_err));
            check($sformatf("gvec%0d_data", v),  64'(bus.global_data), 64'(gv[v].exp_gdata));
        end

        strobe(32'hDEADBEEF);
        check("readout_ready_on", 64'(w_ready_n), 64'd0);
        check("readout_led_on",   64'(bus.status_led_n_out), 64'd0);
        dv0 = mon_dv; fe0 = mon_fe;
        dframe(32, 64'h12345678, seen);
        check("readout_sdo",    seen, 64'hDEADBEEF);
        check("readout_ddata",  64'(bus.daisy_data), 64'h12345678);
        check("readout_dvalid", 64'(mon_dv - dv0), 64'd1);
        check("readout_err",    64'(mon_fe - fe0), 64'd0);
        check("readout_ready_off", 64'(w_ready_n), 64'd1);
        check("readout_led_off",   64'(bus.status_led_n_out), 64'd1);

        dv0 = mon_dv; fe0 = mon_fe;
        dframe(64, 64'hCAFEF00D_0BADC0DE, seen);
        check("pass_sdo",    seen, 64'h00000000_CAFEF00D);
        check("pass_err",    64'(mon_fe - fe0), 64'd1);
        check("pass_dvalid", 64'(mon_dv - dv0), 64'd0);
        check("pass_ddata",  64'(bus.daisy_data), 64'h12345678);

        strobe(32'h11111111);
        dv0 = mon_dv;
        fork
            dframe(32, 64'h55AA55AA, seen);
            begin
                cyc(60);
                strobe(32'h22222222);
            end
        join
        check("mid_sdo_old",   seen, 64'h11111111);
        check("mid_ddata",     64'(bus.daisy_data), 64'h55AA55AA);
        check("mid_ready_kept", 64'(w_ready_n), 64'd0);
        dframe(32, 64'h0, seen);
        check("mid_sdo_new",   seen, 64'h22222222);
        check("mid_dvalid",    64'(mon_dv - dv0), 64'd2);
        check("mid_ready_off", 64'(w_ready_n), 64'd1);

        bus.core_busy = 1'b1;
        for (int t = 0; t < 2; t++) begin
            k = 0;
            prev = bus.status_led_n_out;
            do begin
                cyc(1);
                k++;
            end while (bus.status_led_n_out == prev && k < 40);
            check($sformatf("led_half_period%0d", t), 64'(k), 64'(1 << LD));
        end
        bus.core_busy = 1'b0;
        cyc(1);
        check("led_idle_off", 64'(bus.status_led_n_out), 64'd1);

        strobe(32'h99999999);
        bus.cs0_n_in = 1'b0;
        cyc(H);
        for (int i = 0; i < 10; i++) gbit(1'(i & 1));
        gv0 = mon_gv; fe0 = mon_fe;
        rst_n = 1'b0;
        bus.cs0_n_in = 1'b1;
        cyc(2);
        check("mrst_gdata", 64'(bus.global_data), 64'd0);
        check("mrst_ddata", 64'(bus.daisy_data), 64'd0);
        check("mrst_ready", 64'(w_ready_n), 64'd1);
        check("mrst_led",   64'(bus.status_led_n_out), 64'd1);
        check("mrst_sdo1",  64'(bus.sdo1_out), 64'd0);
        rst_n = 1'b1;
        cyc(5);
        gframe(16, 32'h3C3C);
        check("mrst_valid", 64'(mon_gv - gv0), 64'd1);
        check("mrst_err",   64'(mon_fe - fe0), 64'd0);
        check("mrst_data",  64'(bus.global_data), 64'h3C3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
